// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC conversion sequencer.
package adc_pkg;

  localparam int ADC_W           = 12;
  localparam int CH_W            = 3;
  localparam int N_CH            = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;
  localparam int GAP_CYC_DEF     = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_GO      = 3'd2,
    S_WAIT_DR = 3'd3,
    S_GAP     = 3'd4,
    S_EMIT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } ch_pick_t;

  // Lowest enabled channel at or above ptr; ptr == N_CH means "past the last channel".
  function automatic ch_pick_t pick_ch(input logic [N_CH-1:0] mask, input logic [CH_W:0] ptr);
    ch_pick_t r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(ptr))) begin
        r.found = 1'b1;
        r.idx   = CH_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_fs_sync.sv
// Brings the asynchronous Fs strobe into the iCLK domain and emits a one-cycle rising-edge pulse.
module adc_fs_sync
  import adc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iFS,
  output logic fs_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Registered edge pulse lands SYNC_STAGES+1 cycles after iFS rises.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      fs_edge <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], iFS};
      last_q  <= sync_q[SYNC_STAGES-1];
      fs_edge <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/adc_seq_sched.sv
// Per-frame conversion scheduler: walks enabled channels, oversamples each one via ADC_CTRL
// and emits one averaged, channel-tagged result per channel.
module adc_seq_sched
  import adc_pkg::*;
#(
  parameter int OVS_LOG2    = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iEN,
  input  logic             iFS,
  input  logic [N_CH-1:0]  iCH_MASK,
  input  logic             iCLR,
  output logic             oADC_GO,
  output logic [CH_W-1:0]  oADC_CH,
  input  logic [ADC_W-1:0] iADC_DATA,
  input  logic             iADC_DR,
  output logic [ADC_W-1:0] oSAMPLE,
  output logic [CH_W-1:0]  oSAMPLE_CH,
  output logic             oSAMPLE_VLD,
  output logic             oFRAME_DONE,
  output logic             oBUSY,
  output logic             oOVERRUN,
  output logic             oTIMEOUT
);

  localparam int ACC_W = ADC_W + OVS_LOG2;
  localparam int CNT_W = OVS_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << OVS_LOG2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t             state_q, state_d;
  logic               fs_edge;
  logic [N_CH-1:0]    mask_q;
  logic [CH_W:0]      ptr_q;
  logic [CH_W-1:0]    ch_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [GAP_W-1:0]   gap_q;
  logic               ch_dead_q;
  logic               dr_prev_q;
  logic [ADC_W-1:0]   sample_q;
  logic [CH_W-1:0]    sample_ch_q;
  logic               overrun_q, timeout_q;
  ch_pick_t           pick;
  logic               dr_rise, abort, tmo_evt, gap_end;

  adc_fs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fs_sync (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iFS     (iFS),
    .fs_edge (fs_edge)
  );

  // Handshake with ADC_CTRL: GO rises to request a conversion on oADC_CH and stays high until
  // the first iADC_DR rising edge (data valid in that cycle) or the timeout; it then stays low
  // for GAP_CYC cycles before the next request.
  assign dr_rise = iADC_DR & ~dr_prev_q;
  assign pick    = pick_ch(mask_q, ptr_q);
  assign abort   = (state_q != S_IDLE) && !iEN;
  assign tmo_evt = (state_q == S_WAIT_DR) && iEN && !dr_rise && (tmo_q == TMO_LAST);
  assign gap_end = (gap_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (fs_edge && iEN) state_d = S_SCAN;
      S_SCAN:    state_d = pick.found ? S_GO : S_DONE;
      S_GO:      state_d = S_WAIT_DR;
      S_WAIT_DR: if (dr_rise || tmo_evt) state_d = S_GAP;
      S_GAP: begin
        if (gap_end) begin
          if (ch_dead_q)              state_d = S_SCAN;
          else if (cnt_q == CNT_FULL) state_d = S_EMIT;
          else                        state_d = S_GO;
        end
      end
      S_EMIT:    state_d = S_SCAN;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      ptr_q       <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      ch_dead_q   <= 1'b0;
      dr_prev_q   <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dr_prev_q <= iADC_DR;

      // Set events beat a coincident clear.
      if (fs_edge && (state_q != S_IDLE)) overrun_q <= 1'b1;
      else if (iCLR)                      overrun_q <= 1'b0;
      if (tmo_evt)   timeout_q <= 1'b1;
      else if (iCLR) timeout_q <= 1'b0;

      if (abort) begin
        ptr_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fs_edge && iEN) begin
              mask_q <= iCH_MASK;
              ptr_q  <= '0;
            end
          end
          S_SCAN: begin
            if (pick.found) begin
              ch_q      <= pick.idx;
              ptr_q     <= {1'b0, pick.idx};
              acc_q     <= '0;
              cnt_q     <= '0;
              ch_dead_q <= 1'b0;
            end
          end
          S_GO: begin
            tmo_q <= TMO_W'(1);
            gap_q <= '0;
          end
          S_WAIT_DR: begin
            if (dr_rise) begin
              acc_q <= acc_q + ACC_W'(iADC_DATA);
              cnt_q <= cnt_q + CNT_W'(1);
            end else if (tmo_evt) begin
              ch_dead_q <= 1'b1;
              acc_q     <= '0;
              cnt_q     <= '0;
              ptr_q     <= ptr_q + 4'd1;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          S_GAP: begin
            if (!gap_end) begin
              gap_q <= gap_q + GAP_W'(1);
            end else if (!ch_dead_q && (cnt_q == CNT_FULL)) begin
              sample_q    <= ADC_W'(acc_q >> OVS_LOG2);
              sample_ch_q <= ch_q;
            end
          end
          S_EMIT: ptr_q <= {1'b0, ch_q} + 4'd1;
          S_DONE: ptr_q <= '0;
          default: ;
        endcase
      end
    end
  end

  assign oADC_GO     = (state_q == S_GO) || (state_q == S_WAIT_DR);
  assign oADC_CH     = ch_q;
  assign oSAMPLE     = sample_q;
  assign oSAMPLE_CH  = sample_ch_q;
  assign oSAMPLE_VLD = (state_q == S_EMIT);
  assign oFRAME_DONE = (state_q == S_DONE);
  assign oBUSY       = state_q inside {S_SCAN, S_GO, S_WAIT_DR, S_GAP, S_EMIT};
  assign oOVERRUN    = overrun_q;
  assign oTIMEOUT    = timeout_q;

endmodule

// File: doc/adc_seq_sched.md
Name: adc_seq_sched

Overview:
- Sequences the ADC_CTRL conversion datapath.
- On each sample-rate strobe (the Fs PWM output), walks the enabled ADC channels in ascending order and issues one GO/channel request per conversion.
- Captures 2^OVS_LOG2 conversions per channel and emits one averaged 12-bit result per channel, tagged with its channel number.
- Sits between the Fs generator, ADC_CTRL and the downstream error/filter stage; reports overrun and timeout faults.

Parameters:
- OVS_LOG2, 2, log2 of conversions averaged per channel (0..4).
- TIMEOUT_CYC, 1024, iCLK cycles allowed from GO rise to iADC_DR rise before the channel is abandoned.
- GAP_CYC, 4, minimum iCLK cycles oADC_GO is held low between conversions (>=1).
- SYNC_STAGES, 2, synchronizer depth on iFS (>=2).

Ports:
- iCLK  in  1  system clock; all logic on its rising edge.
- iRST_n  in  1  asynchronous, active-low reset.
- iEN  in  1  scheduler enable.
- iFS  in  1  sample-rate strobe from PWM; asynchronous to iCLK; the rising edge starts a frame.
- iCH_MASK  in  8  channel enable mask; bit n enables channel n.
- iCLR  in  1  clears the sticky fault flags.
- oADC_GO  out  1  conversion request to ADC_CTRL.
- oADC_CH  out  3  channel select to ADC_CTRL.
- iADC_DATA  in  12  conversion result from ADC_CTRL.
- iADC_DR  in  1  data-ready from ADC_CTRL; iCLK domain; the rising edge marks iADC_DATA valid.
- oSAMPLE  out  12  averaged channel result.
- oSAMPLE_CH  out  3  channel tag for oSAMPLE.
- oSAMPLE_VLD  out  1  one-cycle pulse; oSAMPLE/oSAMPLE_CH are valid in that cycle.
- oFRAME_DONE  out  1  one-cycle pulse at the end of each frame.
- oBUSY  out  1  high while a frame is in progress.
- oOVERRUN  out  1  sticky; set when an Fs edge arrives while busy.
- oTIMEOUT  out  1  sticky; set on any conversion timeout.

Behaviour:
- Reset (async, iRST_n=0):
  - State goes to IDLE.
  - All outputs are 0, including oADC_CH=0 and oSAMPLE=0.
  - Accumulator, counters and synchronizer flops are cleared.
- Fs detection:
  - iFS passes through SYNC_STAGES flops, then a rising-edge detect.
  - fs_edge fires SYNC_STAGES+1 cycles after iFS rises.
- States: IDLE, SCAN, GO, WAIT_DR, GAP, EMIT, DONE.
- IDLE:
  - fs_edge with iEN=1: latch iCH_MASK into mask_q, set oBUSY=1, go to SCAN.
  - fs_edge with iEN=0 is ignored.
- SCAN:
  - Find the lowest set bit of mask_q at or above the current pointer.
  - Found: load oADC_CH, clear the accumulator and conversion count, go to GO.
  - None found: go to DONE.
  - mask_q=0 goes directly to DONE: no GO, no samples.
- GO: drive oADC_GO=1, start the timeout counter, go to WAIT_DR.
- WAIT_DR (oADC_GO stays 1):
  - On an iADC_DR rising edge: add iADC_DATA to the accumulator (width 12+OVS_LOG2, unsigned), increment the count, drop GO, go to GAP.
  - On the timeout counter reaching TIMEOUT_CYC first: set oTIMEOUT, drop GO, discard the channel's partial accumulation, advance the pointer past this channel, go to GAP. No sample is emitted for that channel.
- GAP:
  - Hold oADC_GO=0 for GAP_CYC cycles.
  - Then: count < 2^OVS_LOG2 goes to GO; count complete goes to EMIT; a timed-out channel goes to SCAN.
- EMIT:
  - oSAMPLE = accumulator >> OVS_LOG2 (truncate, no rounding), oSAMPLE_CH = channel, oSAMPLE_VLD=1 for exactly one cycle.
  - Advance the pointer, go to SCAN.
  - oSAMPLE/oSAMPLE_CH hold their value until the next EMIT.
- DONE: oFRAME_DONE=1 for one cycle, oBUSY=0, pointer reset to 0, go to IDLE.
- Overrun:
  - fs_edge in any state other than IDLE sets oOVERRUN.
  - That edge is dropped; it is neither queued nor does it restart the frame.
- Fault clearing:
  - iCLR=1 clears oOVERRUN and oTIMEOUT.
  - A set event in the same cycle as iCLR wins (the flag stays 1).
- Abort:
  - iEN deasserted mid-frame returns to IDLE on the next cycle.
  - GO drops, oBUSY drops, no oSAMPLE_VLD and no oFRAME_DONE.
- iADC_DR edges outside WAIT_DR are ignored.
- Mask changes mid-frame have no effect until the next frame.
- Channel 7 wrap: the pointer stops at 7; no wrap to channel 0 within a frame.

Decomposition:
- Shared package (adc_pkg): state encoding constants, ADC_W=12, CH_W=3, default TIMEOUT_CYC/GAP_CYC.
- One sub-module, adc_fs_sync: SYNC_STAGES synchronizer plus rising-edge detector on iFS, outputting fs_edge.
- The FSM, accumulator and timeout counter stay in adc_seq_sched.

Test Plan:
- Mask=8'h05, OVS_LOG2=2, bench ADC model returns 100,102,104,106 on ch0 and 4000 on every ch2 conversion, one Fs edge → exactly 4 GO pulses with CH=0, then 4 with CH=2; oSAMPLE_VLD twice: (103,ch0), then (4000,ch2); then oFRAME_DONE; oBUSY low afterwards.
- Mask=8'h00, Fs edge → oFRAME_DONE within 3 cycles of fs_edge; no GO, no oSAMPLE_VLD.
- Mask=8'h03, model never asserts DR on ch1 → ch0 sample is emitted; oTIMEOUT=1 after 1024 cycles of GO on ch1; no ch1 sample; oFRAME_DONE still pulses.
- Second Fs edge during a busy frame → oOVERRUN=1, frame result unchanged, no second frame. iCLR pulse clears it; iCLR coincident with a new overrun edge leaves oOVERRUN=1.
- iEN dropped while in WAIT_DR on ch0 → next cycle oADC_GO=0, oBUSY=0, no VLD/DONE. Next Fs edge with iEN=1 runs a full frame normally.
- iRST_n asserted mid-GAP → all outputs 0 immediately, asynchronously; after release, the first Fs edge produces a correct frame.
